gbp_ghr_ckpt: RTL and testbench
===============================

Name: gbp_ghr_ckpt

Overview:
- Speculative global-history manager sitting directly upstream of the global branch predictor (gbp). Supplies the history vector that gbp XORs with the fetch PC to form its table index.
- Shifts in each predicted conditional-branch direction at fetch and records a checkpoint per in-flight branch in a circular FIFO.
- On in-order resolution from execute, commits the checkpoint to an architectural history. On a mispredict, restores the speculative history from that checkpoint with the correct outcome.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration (only DebugEn is used).
- HistBits, 9, history length; must equal the predictor's row-index width, $clog2(NR_ROWS).
- NrCkpt, 8, checkpoint FIFO depth; power of two, at least 2.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous reset, active-high.
- flush_bp_i  in  1  clear all history and checkpoints.
- flush_i  in  1  pipeline flush (exception/fence); drop in-flight checkpoints.
- debug_mode_i  in  1  debug mode; suppresses pushes and resolves when CVA6Cfg.DebugEn.
- spec_valid_i  in  1  frontend predicted a conditional branch this cycle.
- spec_taken_i  in  1  predicted direction.
- spec_ready_o  out  1  FIFO not full; a push is accepted only when valid && ready.
- spec_id_o  out  $clog2(NrCkpt)  tag of the checkpoint allocated by the current push (the write pointer).
- ghr_o  out  HistBits  speculative history, driven from a register.
- resolve_valid_i  in  1  branch resolved in execute.
- resolve_id_i  in  $clog2(NrCkpt)  tag of the resolving branch.
- resolve_taken_i  in  1  actual direction.
- resolve_mispredict_i  in  1  direction mispredicted.
- resolve_err_o  out  1  sticky protocol-error flag.

Behaviour:
- State:
  - spec_q[HistBits], arch_q[HistBits].
  - ckpt_q[NrCkpt][HistBits]: each entry holds the history *before* its branch.
  - wr_ptr_q and rd_ptr_q, each $clog2(NrCkpt) wide, wrapping modulo NrCkpt.
  - cnt_q, 0..NrCkpt.
  - err_q.
- Reset (rst_i=1 at a clock edge): all state is 0. Hence ghr_o=0, spec_ready_o=1, spec_id_o=0, resolve_err_o=0.
- Gating: when CVA6Cfg.DebugEn && debug_mode_i, push and resolve are both ignored. Flushes still act.
- Push (spec_valid_i && spec_ready_o):
  - ckpt_q[wr_ptr_q] <= spec_q.
  - spec_q <= {spec_q[HistBits-2:0], spec_taken_i}.
  - wr_ptr_q++, cnt_q++.
  - The new ghr_o is visible the next cycle (1-cycle latency).
- spec_ready_o = (cnt_q != NrCkpt).
- Correct resolve (valid, !mispredict, cnt_q != 0, resolve_id_i == rd_ptr_q):
  - arch_q <= {ckpt_q[rd_ptr_q][HistBits-2:0], resolve_taken_i}.
  - rd_ptr_q++, cnt_q--.
- Mispredict resolve (same legality checks):
  - h = {ckpt_q[rd_ptr_q][HistBits-2:0], resolve_taken_i}.
  - spec_q <= h, arch_q <= h.
  - All younger checkpoints are squashed: wr_ptr_q <= rd_ptr_q+1, rd_ptr_q <= rd_ptr_q+1, cnt_q <= 0.
- Illegal resolve (cnt_q == 0 or resolve_id_i != rd_ptr_q):
  - No state change except err_q <= 1.
  - err_q clears only on reset.
- Simultaneous push + correct resolve: both act. cnt_q is unchanged when the FIFO is neither empty nor full. A push into a full FIFO is still refused even if a resolve frees a slot that cycle (ready is registered-state based).
- Simultaneous push + mispredict: the mispredict wins and the push is dropped. The frontend is being redirected in the same cycle.
- flush_i:
  - spec_q <= arch_q, rd_ptr_q <= wr_ptr_q, cnt_q <= 0.
  - Overrides any same-cycle push or resolve. A correct resolve in that same cycle is lost; execute must not issue one alongside a flush.
- flush_bp_i: spec_q, arch_q, cnt_q and both pointers go to 0. It has highest priority below rst_i.
- Priority: rst_i > flush_bp_i > flush_i > mispredict > correct resolve / push.
- Wrap-around: pointers wrap naturally. Tags are reused only after the owning entry is popped.

Decomposition:
- Shared package entries:
  - ghr_ckpt_id_t = logic [$clog2(NrCkpt)-1:0].
  - A resolve struct bundling valid, id, taken and mispredict, so the branch unit can carry it next to bht_update_t.
- Checkpoint storage is a natural sub-module: ghr_ckpt_fifo. It holds the pointers, count and entry array, with push/pop/squash/clear controls. The top level holds spec/arch registers and the priority logic.

Test Plan:
- Reset then push taken, taken, not-taken → ghr_o = 0b110 (LSB = newest), spec_id_o goes 0→1→2→3, cnt = 3.
- Resolve all three correctly in order (ids 0, 1, 2) → arch_q = 0b110, cnt = 0, ghr_o unchanged, resolve_err_o = 0.
- Push T, T, T (ids 0–2), then mispredict id 0 with taken = 0 → ghr_o = 0b0 next cycle, cnt = 0, next spec_id_o = 1.
- Push NrCkpt = 8 times → spec_ready_o = 0. A ninth valid push leaves ghr_o and cnt unchanged. Resolving id 0 lets the following cycle's push be accepted with spec_id_o = 0 (wrap).
- Arch history = 0b1, push two branches, assert flush_i with a same-cycle push → ghr_o = 0b1, cnt = 0, the push is discarded.
- Resolve with an empty FIFO, or with id 2 while oldest is 0 → resolve_err_o = 1 and sticky, history unchanged. Pushes during debug_mode_i (DebugEn = 1) are ignored. flush_bp_i zeroes ghr_o.

Source files
------------

// File: rtl/gbp_ghr_ckpt_pkg.sv
// gbp_ghr_ckpt_pkg: shared types for the speculative global-history checkpoint manager
package gbp_ghr_ckpt_pkg;
  typedef struct packed {
    logic DebugEn;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '0;
  localparam int unsigned HIST_BITS = 9;
  localparam int unsigned NR_CKPT = 8;
  localparam int unsigned CKPT_ID_W = $clog2(NR_CKPT);
  typedef logic [CKPT_ID_W-1:0] ghr_ckpt_id_t;
  typedef struct packed {
    logic         valid;
    ghr_ckpt_id_t id;
    logic         taken;
    logic         mispredict;
  } ghr_resolve_t;
endpackage

// File: rtl/gbp_ghr_ckpt_fifo.sv
// gbp_ghr_ckpt_fifo: circular checkpoint store with push/pop/squash/flush/clear controls
module gbp_ghr_ckpt_fifo
  import gbp_ghr_ckpt_pkg::*;
#(
  parameter int unsigned W  = HIST_BITS,
  parameter int unsigned N  = NR_CKPT,
  parameter int unsigned IW = $clog2(N),
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          flush_i,
  input  logic          squash_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [IW-1:0] wr_ptr_o,
  output logic [IW-1:0] rd_ptr_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  ckpt_q [N];
  logic [W-1:0]  ckpt_d [N];
  logic [IW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drop;
  always_comb begin
    drop     = clear_i || flush_i || squash_i;
    ckpt_d   = ckpt_q;
    if (push_i && !drop) ckpt_d[wr_ptr_q] = wdata_i;
    wr_ptr_d = clear_i ? '0 : flush_i ? wr_ptr_q : squash_i ? rd_ptr_q + IW'(1) : wr_ptr_q + IW'(push_i);
    rd_ptr_d = clear_i ? '0 : flush_i ? wr_ptr_q : squash_i ? rd_ptr_q + IW'(1) : rd_ptr_q + IW'(pop_i);
    cnt_d    = drop ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(N); i++) ckpt_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      ckpt_q   <= ckpt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  assign rdata_o  = ckpt_q[rd_ptr_q];
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign full_o   = cnt_q == CW'(N);
  assign empty_o  = cnt_q == '0;
endmodule

// File: rtl/gbp_ghr_ckpt.sv
// gbp_ghr_ckpt: speculative/architectural global history with per-branch checkpoints
module gbp_ghr_ckpt
  import gbp_ghr_ckpt_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg  = cva6_cfg_empty,
  parameter int unsigned HistBits = HIST_BITS,
  parameter int unsigned NrCkpt   = NR_CKPT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_bp_i,
  input  logic                      flush_i,
  input  logic                      debug_mode_i,
  input  logic                      spec_valid_i,
  input  logic                      spec_taken_i,
  output logic                      spec_ready_o,
  output logic [$clog2(NrCkpt)-1:0] spec_id_o,
  output logic [HistBits-1:0]       ghr_o,
  input  logic                      resolve_valid_i,
  input  logic [$clog2(NrCkpt)-1:0] resolve_id_i,
  input  logic                      resolve_taken_i,
  input  logic                      resolve_mispredict_i,
  output logic                      resolve_err_o
);
  localparam int unsigned IdW = $clog2(NrCkpt);
  logic [HistBits-1:0] spec_q, spec_d, arch_q, arch_d, ck_rd, h;
  logic [IdW-1:0]      wr_ptr, rd_ptr;
  logic                err_q, err_d, full, empty;
  logic                gate, push, res, legal, mis, ok;
  always_comb begin
    gate   = !(CVA6Cfg.DebugEn && debug_mode_i);
    push   = gate && spec_valid_i && !full;
    // a resolve coinciding with any flush is dropped and cannot raise the error flag
    res    = gate && resolve_valid_i && !flush_i && !flush_bp_i;
    legal  = res && !empty && resolve_id_i == rd_ptr;
    mis    = legal && resolve_mispredict_i;
    ok     = legal && !resolve_mispredict_i;
    h      = {ck_rd[HistBits-2:0], resolve_taken_i};
    spec_d = flush_bp_i ? '0 : flush_i ? arch_q : mis ? h :
             push ? {spec_q[HistBits-2:0], spec_taken_i} : spec_q;
    arch_d = flush_bp_i ? '0 : legal ? h : arch_q;
    err_d  = err_q || (res && !legal);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spec_q <= '0;
      arch_q <= '0;
      err_q  <= 1'b0;
    end else begin
      spec_q <= spec_d;
      arch_q <= arch_d;
      err_q  <= err_d;
    end
  end
  gbp_ghr_ckpt_fifo #(
    .W(HistBits),
    .N(NrCkpt)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (flush_bp_i),
    .flush_i  (flush_i),
    .squash_i (mis),
    .push_i   (push && !mis),
    .pop_i    (ok),
    .wdata_i  (spec_q),
    .rdata_o  (ck_rd),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .full_o   (full),
    .empty_o  (empty)
  );
  assign spec_ready_o  = !full;
  assign spec_id_o     = wr_ptr;
  assign ghr_o         = spec_q;
  assign resolve_err_o = err_q;
endmodule

// File: tb/tb_gbp_ghr_ckpt.sv
// tb_gbp_ghr_ckpt: scoreboard bench comparing the DUT against a behavioural history model
module tb_gbp_ghr_ckpt;
  import gbp_ghr_ckpt_pkg::*;
  logic       clk_i = 1'b0;
  logic       rst_i, flush_bp_i, flush_i, debug_mode_i;
  logic       spec_valid_i, spec_taken_i, spec_ready_o;
  logic [2:0] spec_id_o, resolve_id_i;
  logic [8:0] ghr_o;
  logic       resolve_valid_i, resolve_taken_i, resolve_mispredict_i, resolve_err_o;
  int         n_chk = 0, n_pass = 0;
  typedef struct {
    logic [8:0] ghr;
    logic       rdy;
    logic [2:0] id;
    logic       err;
  } exp_t;
  exp_t       sb[$];
  logic [8:0] m_spec, m_arch;
  logic [8:0] m_ck[8];
  logic [2:0] m_wr, m_rd;
  int         m_cnt;
  logic       m_err;
  always #5 clk_i = ~clk_i;
  gbp_ghr_ckpt #(
    .CVA6Cfg('{DebugEn: 1'b1}),
    .HistBits(9),
    .NrCkpt(8)
  ) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .flush_bp_i           (flush_bp_i),
    .flush_i              (flush_i),
    .debug_mode_i         (debug_mode_i),
    .spec_valid_i         (spec_valid_i),
    .spec_taken_i         (spec_taken_i),
    .spec_ready_o         (spec_ready_o),
    .spec_id_o            (spec_id_o),
    .ghr_o                (ghr_o),
    .resolve_valid_i      (resolve_valid_i),
    .resolve_id_i         (resolve_id_i),
    .resolve_taken_i      (resolve_taken_i),
    .resolve_mispredict_i (resolve_mispredict_i),
    .resolve_err_o        (resolve_err_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic step(input logic sv, st, rv, input logic [2:0] rid, input logic rt, rm, fl, fb, dbg);
    logic       gate, push, res, legal;
    logic [8:0] h;
    exp_t       e;
    spec_valid_i = sv; spec_taken_i = st;
    resolve_valid_i = rv; resolve_id_i = rid; resolve_taken_i = rt; resolve_mispredict_i = rm;
    flush_i = fl; flush_bp_i = fb; debug_mode_i = dbg;
    gate  = !dbg;
    push  = gate && sv && m_cnt != 8;
    res   = gate && rv && !fl && !fb;
    legal = res && m_cnt != 0 && rid == m_rd;
    h     = {m_ck[m_rd][7:0], rt};
    if (res && !legal) m_err = 1'b1;
    if (fb) begin
      m_spec = '0; m_arch = '0; m_wr = '0; m_rd = '0; m_cnt = 0;
    end else if (fl) begin
      m_spec = m_arch; m_rd = m_wr; m_cnt = 0;
    end else if (legal && rm) begin
      m_spec = h; m_arch = h; m_rd = m_rd + 3'd1; m_wr = m_rd; m_cnt = 0;
    end else begin
      if (legal) begin
        m_arch = h; m_rd = m_rd + 3'd1; m_cnt--;
      end
      if (push) begin
        m_ck[m_wr] = m_spec; m_spec = {m_spec[7:0], st}; m_wr = m_wr + 3'd1; m_cnt++;
      end
    end
    e.ghr = m_spec; e.rdy = m_cnt != 8; e.id = m_wr; e.err = m_err;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    chk("ghr", 32'(ghr_o), 32'(e.ghr));
    chk("ready", 32'(spec_ready_o), 32'(e.rdy));
    chk("id", 32'(spec_id_o), 32'(e.id));
    chk("err", 32'(resolve_err_o), 32'(e.err));
    {spec_valid_i, spec_taken_i, resolve_valid_i, resolve_taken_i, resolve_mispredict_i} = '0;
    {flush_i, flush_bp_i, debug_mode_i} = '0;
    resolve_id_i = '0;
  endtask
  task automatic push_br(input logic t);
    step(1, t, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic resolve(input logic [2:0] id, input logic t, m);
    step(0, 0, 1, id, t, m, 0, 0, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    {spec_valid_i, spec_taken_i, resolve_valid_i, resolve_taken_i, resolve_mispredict_i} = '0;
    {flush_i, flush_bp_i, debug_mode_i} = '0;
    resolve_id_i = '0;
    m_spec = '0; m_arch = '0; m_wr = '0; m_rd = '0; m_cnt = 0; m_err = 1'b0;
    for (int i = 0; i < 8; i++) m_ck[i] = '0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_ghr", 32'(ghr_o), 0);
    chk("rst_ready", 32'(spec_ready_o), 1);
    chk("rst_id", 32'(spec_id_o), 0);
    chk("rst_err", 32'(resolve_err_o), 0);
    push_br(1); push_br(1); push_br(0);
    chk("tp_ghr", 32'(ghr_o), 32'h6);
    chk("tp_id", 32'(spec_id_o), 3);
    resolve(0, 1, 0); resolve(1, 1, 0); resolve(2, 0, 0);
    chk("res_ghr", 32'(ghr_o), 32'h6);
    chk("res_err", 32'(resolve_err_o), 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("arch_via_flush", 32'(ghr_o), 32'h6);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    push_br(1); push_br(1); push_br(1);
    step(1, 1, 1, 0, 0, 1, 0, 0, 0);
    chk("mis_ghr", 32'(ghr_o), 0);
    chk("mis_id", 32'(spec_id_o), 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) push_br(1'($urandom_range(0, 1)));
    chk("full_ready", 32'(spec_ready_o), 0);
    push_br(1);
    step(1, 1, 1, 0, 1, 0, 0, 0, 0);
    chk("wrap_id", 32'(spec_id_o), 0);
    chk("wrap_ready", 32'(spec_ready_o), 1);
    push_br(0);
    chk("wrap_push_id", 32'(spec_id_o), 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    push_br(1); resolve(0, 1, 0);
    push_br(0); push_br(1);
    step(1, 1, 0, 0, 0, 0, 1, 0, 0);
    chk("flush_ghr", 32'(ghr_o), 1);
    chk("flush_ready", 32'(spec_ready_o), 1);
    resolve(3, 1, 0);
    chk("err_empty", 32'(resolve_err_o), 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    push_br(1); push_br(0); push_br(1);
    resolve(2, 0, 1);
    chk("err_sticky", 32'(resolve_err_o), 1);
    step(1, 1, 1, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("fbp_ghr", 32'(ghr_o), 0);
    for (int i = 0; i < 300; i++) begin
      logic [2:0] rid;
      rid = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : m_rd;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, rid,
           1'($urandom_range(0, 1)), $urandom_range(0, 6) == 0, $urandom_range(0, 30) == 0,
           $urandom_range(0, 60) == 0, $urandom_range(0, 15) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
